// File: rtl/fifo_tx_drain_pkg.sv
// fifo_drain_pkg
// Shared definitions for the FIFO-to-UART drain controller: the FSM state
// encoding and its width.
// No ports (package only).

package fifo_drain_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    VALID     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } drain_state_e;

endpackage

// File: rtl/fifo_tx_drain_if.sv
// fifo_tx_drain_if
// Bundles the FIFO read-side and UART TX handshake signals between the drain
// controller and its surroundings.
// Signals:
//   fifo_empty     FIFO r_empty
//   fifo_rd_data   FIFO r_data (combinational at current read address)
//   fifo_rd_inc    FIFO rinc, one cycle per popped word
//   tx_busy        UART TX busy
//   tx_p_data      word presented to the UART transmitter
//   tx_data_valid  one-cycle pulse qualifying tx_p_data
// Modports:
//   master  the drain controller
//   slave   FIFO + UART environment

interface fifo_tx_drain_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_inc;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_p_data;
  logic                  tx_data_valid;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  tx_busy,
    output fifo_rd_inc,
    output tx_p_data,
    output tx_data_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output tx_busy,
    input  fifo_rd_inc,
    input  tx_p_data,
    input  tx_data_valid
  );

endinterface

// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain
// Read-side consumer of the async FIFO in the UART clock domain. Pops one
// word at a time, presents it to the UART transmitter with a one-cycle valid
// pulse, and waits for tx_busy to rise and fall before the next pop. If busy
// never rises, valid is re-pulsed with the same word and timeout_err is set.
// Ports:
//   CLK          FIFO read-domain clock
//   RST          synchronous active-high reset
//   en           drain enable, only looked at in IDLE
//   dif          FIFO/UART handshake bundle (master side)
//   drain_busy   high whenever the FSM is not in IDLE
//   timeout_err  sticky busy-timeout flag, cleared only by RST
//   tx_count     words acknowledged by the UART, wraps
//                (only with FIFO_DRAIN_STATS_EN defined)
// Build option: define FIFO_DRAIN_STATS_EN to add the tx_count port/counter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | parked; pop when enabled and FIFO non-empty
// POP       | rinc high; word captured at the exiting edge
// VALID     | tx_data_valid high for one cycle; timeout counter cleared
// WAIT_BUSY | waiting for tx_busy to rise; times out into VALID
// WAIT_DONE | waiting for tx_busy to fall; then back to IDLE

module fifo_tx_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
`ifdef FIFO_DRAIN_STATS_EN
  ,
  parameter int CNT_WIDTH    = 16
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  fifo_tx_drain_if.master      dif,
  output logic                 drain_busy,
  output logic                 timeout_err
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] tx_count
`endif
);

  localparam int TO_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

`ifdef FIFO_DRAIN_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
`endif

  drain_state_e    state;
  logic [TO_W-1:0] to_cnt;

  // Outputs are set on the transition into the state that owns them, so
  // they line up exactly with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      to_cnt            <= '0;
      dif.fifo_rd_inc   <= 1'b0;
      dif.tx_p_data     <= '0;
      dif.tx_data_valid <= 1'b0;
      drain_busy        <= 1'b0;
      timeout_err       <= 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
      tx_count          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en && !dif.fifo_empty) begin
            state           <= POP;
            dif.fifo_rd_inc <= 1'b1;
            drain_busy      <= 1'b1;
          end
        end

        // fifo_empty is not rechecked: only our own pops can empty the FIFO.
        // rd_data still reflects the pre-increment address at this edge.
        POP: begin
          dif.tx_p_data     <= dif.fifo_rd_data;
          dif.fifo_rd_inc   <= 1'b0;
          dif.tx_data_valid <= 1'b1;
          state             <= VALID;
        end

        VALID: begin
          dif.tx_data_valid <= 1'b0;
          to_cnt            <= '0;
          state             <= WAIT_BUSY;
        end

        // busy already high on entry counts as the acknowledge.
        WAIT_BUSY: begin
          if (dif.tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            timeout_err       <= 1'b1;
            dif.tx_data_valid <= 1'b1;
            state             <= VALID;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end

        WAIT_DONE: begin
          if (!dif.tx_busy) begin
            state      <= IDLE;
            drain_busy <= 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
            tx_count   <= tx_count + CNT_ONE;
`endif
          end
        end

        default: begin
          state             <= IDLE;
          dif.fifo_rd_inc   <= 1'b0;
          dif.tx_data_valid <= 1'b0;
          drain_busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// tb_fifo_tx_drain
// Directed bench for fifo_tx_drain: behavioural FIFO (array + pointers),
// a UART model that raises busy 2 cycles after valid for 10 cycles (or never,
// in mode 1), and a negedge monitor logging rinc/valid activity.

module tb_fifo_tx_drain;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic drain_busy;
  logic timeout_err;
`ifdef FIFO_DRAIN_STATS_EN
  logic [7:0] tx_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_tx_drain_if #(.DATA_WIDTH(8)) dif ();

  fifo_tx_drain #(
    .DATA_WIDTH  (8),
    .BUSY_TIMEOUT(16)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .CNT_WIDTH   (8)
`endif
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .en         (en),
    .dif        (dif),
    .drain_busy (drain_busy),
    .timeout_err(timeout_err)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .tx_count   (tx_count)
`endif
  );

  // FIFO model
  logic [7:0] mem [512];
  logic [8:0] rptr = '0;
  logic [8:0] wptr = '0;

  assign dif.fifo_empty   = (rptr == wptr);
  assign dif.fifo_rd_data = mem[rptr];

  always @(posedge clk) begin
    if (dif.fifo_rd_inc) rptr <= rptr + 9'd1;
  end

  // UART model
  logic uart_busy = 1'b0;
  int   uart_mode = 0;
  assign dif.tx_busy = uart_busy;

  initial begin
    forever begin
      @(negedge clk);
      if (uart_mode == 0 && dif.tx_data_valid) begin
        repeat (2) @(negedge clk);
        uart_busy = 1'b1;
        repeat (10) @(negedge clk);
        uart_busy = 1'b0;
      end
    end
  end

  // Monitor
  int         cyc = 0;
  int         rinc_cnt = 0;
  int         b2b_viol = 0;
  logic       busy_seen = 1'b0;
  logic       have_prev = 1'b0;
  logic [7:0] valid_q [$];
  int         valid_cyc [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (dif.fifo_rd_inc) rinc_cnt = rinc_cnt + 1;
      if (dif.tx_busy) busy_seen = 1'b1;
      if (dif.tx_data_valid) begin
        if (have_prev && !busy_seen) b2b_viol = b2b_viol + 1;
        busy_seen = 1'b0;
        have_prev = 1'b1;
        valid_q.push_back(dif.tx_p_data);
        valid_cyc.push_back(cyc);
      end
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wptr] = d;
    wptr = wptr + 9'd1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dif.fifo_rd_inc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b exp 0", dif.fifo_rd_inc); end
    checks++;
    if (dif.tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dif.tx_data_valid); end
    checks++;
    if (dif.tx_p_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", dif.tx_p_data); end
    checks++;
    if (drain_busy !== 1'b0) begin errors++; $display("FAIL reset_drain_busy got %b exp 0", drain_busy); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
`ifdef FIFO_DRAIN_STATS_EN
    checks++;
    if (tx_count !== 8'd0) begin errors++; $display("FAIL reset_tx_count got %0d exp 0", tx_count); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int r0, v0, n;
    r0 = rinc_cnt;
    v0 = valid_q.size();
    push(8'hA5);
    en = 1'b1;
    n = 0;
    while (!drain_busy && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (drain_busy && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (drain_busy !== 1'b0) begin errors++; $display("FAIL single_done drain_busy got %b exp 0", drain_busy); end
    checks++;
    if (rinc_cnt - r0 != 1) begin errors++; $display("FAIL single_rinc got %0d exp 1", rinc_cnt - r0); end
    checks++;
    if (valid_q.size() - v0 != 1) begin errors++; $display("FAIL single_valid_cnt got %0d exp 1", valid_q.size() - v0); end
    else begin
      checks++;
      if (valid_q[v0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", valid_q[v0]); end
    end
    checks++;
    if (dif.tx_p_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h exp a5", dif.tx_p_data); end
    checks++;
    if (dif.fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", dif.fifo_empty); end
`ifdef FIFO_DRAIN_STATS_EN
    checks++;
    if (tx_count !== 8'd1) begin errors++; $display("FAIL single_tx_count got %0d exp 1", tx_count); end
`endif
  endtask

  task automatic test_burst;
    int r0, v0, b0, n;
    logic [7:0] exp_d;
    r0 = rinc_cnt;
    v0 = valid_q.size();
    b0 = b2b_viol;
    for (int i = 1; i <= 4; i++) push(8'(i));
    n = 0;
    @(negedge clk);
    while ((wptr != rptr || drain_busy) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL burst_timeout got %0d cycles exp <300", n); end
    checks++;
    if (rinc_cnt - r0 != 4) begin errors++; $display("FAIL burst_rinc got %0d exp 4", rinc_cnt - r0); end
    checks++;
    if (valid_q.size() - v0 != 4) begin errors++; $display("FAIL burst_valid_cnt got %0d exp 4", valid_q.size() - v0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'(i + 1);
        checks++;
        if (valid_q[v0+i] !== exp_d) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", i, valid_q[v0+i], exp_d); end
      end
    end
    checks++;
    if (b2b_viol - b0 != 0) begin errors++; $display("FAIL burst_b2b got %0d exp 0", b2b_viol - b0); end
  endtask

  task automatic test_enable;
    int r0, v0, n;
    en = 1'b0;
    @(negedge clk);
    r0 = rinc_cnt;
    v0 = valid_q.size();
    push(8'h3C);
    repeat (20) @(negedge clk);
    checks++;
    if (rinc_cnt - r0 != 0) begin errors++; $display("FAIL en_gate_rinc got %0d exp 0", rinc_cnt - r0); end
    checks++;
    if (drain_busy !== 1'b0) begin errors++; $display("FAIL en_gate_busy got %b exp 0", drain_busy); end
    push(8'h7E);
    push(8'h81);
    en = 1'b1;
    n = 0;
    while (!dif.tx_busy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    en = 1'b0;
    n = 0;
    while (drain_busy && n < 50) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    checks++;
    if (rinc_cnt - r0 != 1) begin errors++; $display("FAIL en_drop_rinc got %0d exp 1", rinc_cnt - r0); end
    checks++;
    if (valid_q.size() - v0 != 1) begin errors++; $display("FAIL en_drop_valid_cnt got %0d exp 1", valid_q.size() - v0); end
    else begin
      checks++;
      if (valid_q[v0] !== 8'h3C) begin errors++; $display("FAIL en_drop_data got %h exp 3c", valid_q[v0]); end
    end
    checks++;
    if (wptr - rptr != 9'd2) begin errors++; $display("FAIL en_drop_left got %0d exp 2", wptr - rptr); end
    checks++;
    if (drain_busy !== 1'b0) begin errors++; $display("FAIL en_drop_park got %b exp 0", drain_busy); end
    wptr = rptr;
  endtask

  task automatic test_timeout;
    int r0, v0;
    r0 = rinc_cnt;
    v0 = valid_q.size();
    uart_mode = 1;
    push(8'h5A);
    en = 1'b1;
    // valids expected at monitor offsets 2, 19, 36, 53; the next would be 70
    repeat (62) @(negedge clk);
    checks++;
    if (valid_q.size() - v0 != 4) begin errors++; $display("FAIL to_valid_cnt got %0d exp 4", valid_q.size() - v0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (valid_q[v0+i] !== 8'h5A) begin errors++; $display("FAIL to_data[%0d] got %h exp 5a", i, valid_q[v0+i]); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (valid_cyc[v0+i] - valid_cyc[v0+i-1] != 17) begin
          errors++;
          $display("FAIL to_period[%0d] got %0d exp 17", i, valid_cyc[v0+i] - valid_cyc[v0+i-1]);
        end
      end
    end
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", timeout_err); end
    checks++;
    if (rinc_cnt - r0 != 1) begin errors++; $display("FAIL to_rinc got %0d exp 1", rinc_cnt - r0); end
    checks++;
    if (drain_busy !== 1'b1) begin errors++; $display("FAIL to_drain_busy got %b exp 1", drain_busy); end
  endtask

  // Entered with the FSM sitting in WAIT_BUSY from the timeout scenario.
  task automatic test_reset_midop;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (drain_busy !== 1'b0) begin errors++; $display("FAIL rmid_drain_busy got %b exp 0", drain_busy); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_timeout_err got %b exp 0", timeout_err); end
    checks++;
    if (dif.tx_p_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h exp 00", dif.tx_p_data); end
    checks++;
    if (dif.tx_data_valid !== 1'b0 || dif.fifo_rd_inc !== 1'b0) begin
      errors++;
      $display("FAIL rmid_strobes got valid=%b rinc=%b exp 0/0", dif.tx_data_valid, dif.fifo_rd_inc);
    end
    rst = 1'b0;
    en = 1'b0;
    uart_mode = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (drain_busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b exp 0", drain_busy); end
  endtask

`ifdef FIFO_DRAIN_STATS_EN
  task automatic test_stats;
    int r0, n;
    r0 = rinc_cnt;
    for (int i = 0; i < 300; i++) push(8'(i));
    en = 1'b1;
    n = 0;
    @(negedge clk);
    while ((wptr != rptr || drain_busy) && n < 10000) begin @(negedge clk); n++; end
    checks++;
    if (rinc_cnt - r0 != 300) begin errors++; $display("FAIL stats_rinc got %0d exp 300", rinc_cnt - r0); end
    checks++;
    if (tx_count !== 8'd44) begin errors++; $display("FAIL stats_tx_count got %0d exp 44", tx_count); end
    en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    test_reset;
    test_single;
    test_burst;
    test_enable;
    test_timeout;
    test_reset_midop;
`ifdef FIFO_DRAIN_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
